// File: rtl/min_queue_param_if.sv
// Handshake and status bundle for min_queue_param.
// The master side drives requests; the slave side (the queue) drives status.
interface min_queue_param_if #(
   parameter int REC_WD = 48,
   parameter int CNT_WD = 5
);
   logic              clear;
   logic              push;
   logic [REC_WD-1:0] push_record;
   logic              push_wait;
   logic              full;
   logic              pop;
   logic [REC_WD-1:0] pop_record;
   logic              min_valid;
   logic              empty;
   logic [CNT_WD-1:0] count;
   logic              overflow;
   logic              underflow;

   modport master (
      output clear, push, push_record, pop,
      input  push_wait, full, pop_record, min_valid, empty, count, overflow, underflow
   );

   modport slave (
      input  clear, push, push_record, pop,
      output push_wait, full, pop_record, min_valid, empty, count, overflow, underflow
   );
endinterface

// File: rtl/min_queue_param.sv
// Register-based sorted priority queue: slot 0 always holds the best record,
// push and pop complete in one cycle and equal keys leave in arrival order.
module min_queue_param #(
   parameter int REC_WD   = 48,
   parameter int KEY_WD   = 16,
   parameter int KEY_LSB  = 32,
   parameter int DEPTH    = 16,
   parameter int CNT_WD   = 5,
   parameter int MAX_MODE = 0
) (
   input  logic                clk,
   input  logic                rst_b,
   min_queue_param_if.slave    bus
);

   logic [DEPTH-1:0][REC_WD-1:0] slot_data_reg;
   logic [DEPTH-1:0][REC_WD-1:0] slot_data_next;
   logic [DEPTH-1:0][REC_WD-1:0] base_data;
   logic [DEPTH-1:0]             slot_valid_reg;
   logic [DEPTH-1:0]             slot_valid_next;
   logic [DEPTH-1:0]             base_valid;
   logic [DEPTH-1:0]             precedes;
   logic [CNT_WD-1:0]            count_reg;
   logic [CNT_WD-1:0]            count_next;
   logic                         full_reg;
   logic                         empty_reg;
   logic                         overflow_reg;
   logic                         underflow_reg;
   logic                         pop_acc;
   logic                         push_acc;
   logic [KEY_WD-1:0]            new_key;

   assign pop_acc  = bus.pop & slot_valid_reg[0];
   assign push_acc = bus.push & (~full_reg | pop_acc);
   assign new_key  = bus.push_record[KEY_LSB +: KEY_WD];

   // Every slot compares against the incoming key in parallel; the new record
   // lands at the first slot whose (post-pop) occupant does not precede it.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [KEY_WD-1:0] slot_key;

      if (gi == DEPTH-1) begin : g_last
         assign base_data[gi]  = pop_acc ? '0 : slot_data_reg[gi];
         assign base_valid[gi] = ~pop_acc & slot_valid_reg[gi];
      end else begin : g_mid
         assign base_data[gi]  = pop_acc ? slot_data_reg[gi+1] : slot_data_reg[gi];
         assign base_valid[gi] = pop_acc ? slot_valid_reg[gi+1] : slot_valid_reg[gi];
      end

      assign slot_key = base_data[gi][KEY_LSB +: KEY_WD];

      // Ties count as preceding, which keeps equal keys in arrival order.
      if (MAX_MODE != 0) begin : g_max
         assign precedes[gi] = base_valid[gi] & (slot_key >= new_key);
      end else begin : g_min
         assign precedes[gi] = base_valid[gi] & (slot_key <= new_key);
      end

      if (gi == 0) begin : g_head
         assign slot_data_next[gi]  = (!push_acc || precedes[gi]) ? base_data[gi] : bus.push_record;
         assign slot_valid_next[gi] = (!push_acc || precedes[gi]) ? base_valid[gi] : 1'b1;
      end else begin : g_tail
         logic insert_here;
         assign insert_here = precedes[gi-1] & ~precedes[gi];
         assign slot_data_next[gi]  = (!push_acc || precedes[gi]) ? base_data[gi] :
                                      insert_here ? bus.push_record : base_data[gi-1];
         assign slot_valid_next[gi] = (!push_acc || precedes[gi]) ? base_valid[gi] :
                                      insert_here ? 1'b1 : base_valid[gi-1];
      end
   end

   assign count_next = count_reg + CNT_WD'(push_acc) - CNT_WD'(pop_acc);

   always_ff @(posedge clk) begin
      if (rst_b || bus.clear) begin
         slot_data_reg  <= '0;
         slot_valid_reg <= '0;
         count_reg      <= '0;
         full_reg       <= 1'b0;
         empty_reg      <= 1'b1;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
      end else begin
         slot_data_reg  <= slot_data_next;
         slot_valid_reg <= slot_valid_next;
         count_reg      <= count_next;
         full_reg       <= (count_next == CNT_WD'(DEPTH));
         empty_reg      <= (count_next == '0);
         if (bus.push && full_reg && !pop_acc) begin
            overflow_reg <= 1'b1;
         end
         if (bus.pop && !slot_valid_reg[0]) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign bus.pop_record = slot_data_reg[0];
   assign bus.min_valid  = slot_valid_reg[0];
   assign bus.count      = count_reg;
   assign bus.full       = full_reg;
   assign bus.push_wait  = full_reg;
   assign bus.empty      = empty_reg;
   assign bus.overflow   = overflow_reg;
   assign bus.underflow  = underflow_reg;

endmodule

// File: tb/tb_min_queue_param.sv
// Directed bench for min_queue_param: a 4-deep min queue and a 4-deep max
// queue driven through scenario tasks with hand-computed expectations.
module tb_min_queue_param;
   localparam int REC_WD = 48;
   localparam int CNT_WD = 3;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   int   vectors = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   min_queue_param_if #(.REC_WD(REC_WD), .CNT_WD(CNT_WD)) bus0 ();
   min_queue_param_if #(.REC_WD(REC_WD), .CNT_WD(CNT_WD)) bus1 ();

   min_queue_param #(
      .REC_WD(REC_WD), .KEY_WD(16), .KEY_LSB(32), .DEPTH(DEPTH), .CNT_WD(CNT_WD), .MAX_MODE(0)
   ) dut_min (
      .clk(clk), .rst_b(rst_b), .bus(bus0)
   );

   min_queue_param #(
      .REC_WD(REC_WD), .KEY_WD(16), .KEY_LSB(32), .DEPTH(DEPTH), .CNT_WD(CNT_WD), .MAX_MODE(1)
   ) dut_max (
      .clk(clk), .rst_b(rst_b), .bus(bus1)
   );

   // Key in bits 47:32, tag in the low byte to tell equal keys apart.
   function automatic logic [47:0] mk(input logic [15:0] key, input logic [7:0] tag);
      return {key, 24'h0, tag};
   endfunction

   task automatic cyc0(input logic psh, input logic [47:0] rec, input logic pp, input logic clr);
      bus0.push = psh; bus0.push_record = rec; bus0.pop = pp; bus0.clear = clr;
      @(posedge clk); #1;
      bus0.push = 1'b0; bus0.push_record = '0; bus0.pop = 1'b0; bus0.clear = 1'b0;
      $display("minq push=%b rec=%h pop=%b clear=%b -> count=%0d top=%h valid=%b ovf=%b udf=%b",
               psh, rec, pp, clr, bus0.count, bus0.pop_record, bus0.min_valid, bus0.overflow, bus0.underflow);
   endtask

   task automatic cyc1(input logic psh, input logic [47:0] rec, input logic pp);
      bus1.push = psh; bus1.push_record = rec; bus1.pop = pp; bus1.clear = 1'b0;
      @(posedge clk); #1;
      bus1.push = 1'b0; bus1.push_record = '0; bus1.pop = 1'b0;
      $display("maxq push=%b rec=%h pop=%b -> count=%0d top=%h valid=%b",
               psh, rec, pp, bus1.count, bus1.pop_record, bus1.min_valid);
   endtask

   task automatic test_reset();
      rst_b = 1'b1;
      bus0.push = 1'b1; bus0.push_record = mk(16'd1, 8'd1); bus0.pop = 1'b1;
      @(posedge clk); #1;
      bus0.push = 1'b0; bus0.pop = 1'b0; bus0.push_record = '0;
      vectors++; if (bus0.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus0.count); end
      vectors++; if (bus0.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus0.empty); end
      vectors++; if (bus0.full !== 1'b0 || bus0.push_wait !== 1'b0) begin errors++; $display("FAIL reset_full: got full=%b push_wait=%b expected 0/0", bus0.full, bus0.push_wait); end
      vectors++; if (bus0.min_valid !== 1'b0 || bus0.pop_record !== 48'h0) begin errors++; $display("FAIL reset_head: got valid=%b rec=%h expected 0/0", bus0.min_valid, bus0.pop_record); end
      vectors++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0/0", bus0.overflow, bus0.underflow); end
      vectors++; if (bus1.count !== 3'd0 || bus1.empty !== 1'b1) begin errors++; $display("FAIL reset_maxq: got count=%0d empty=%b expected 0/1", bus1.count, bus1.empty); end
      rst_b = 1'b0;
   endtask

   task automatic test_sorted_drain();
      logic [47:0] exp_q [4];
      exp_q[0] = mk(16'd3, 8'd2); exp_q[1] = mk(16'd3, 8'd4);
      exp_q[2] = mk(16'd7, 8'd1); exp_q[3] = mk(16'd9, 8'd3);
      cyc0(1'b1, mk(16'd7, 8'd1), 1'b0, 1'b0);
      vectors++; if (bus0.min_valid !== 1'b1 || bus0.pop_record !== mk(16'd7, 8'd1)) begin errors++; $display("FAIL drain_first_push: got valid=%b rec=%h expected 1/%h", bus0.min_valid, bus0.pop_record, mk(16'd7, 8'd1)); end
      cyc0(1'b1, mk(16'd3, 8'd2), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd9, 8'd3), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd3, 8'd4), 1'b0, 1'b0);
      vectors++; if (bus0.full !== 1'b1 || bus0.push_wait !== 1'b1 || bus0.count !== 3'd4) begin errors++; $display("FAIL drain_full: got full=%b push_wait=%b count=%0d expected 1/1/4", bus0.full, bus0.push_wait, bus0.count); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (bus0.pop_record !== exp_q[i]) begin errors++; $display("FAIL drain_pop%0d: got %h expected %h", i, bus0.pop_record, exp_q[i]); end
         cyc0(1'b0, '0, 1'b1, 1'b0);
      end
      vectors++; if (bus0.empty !== 1'b1 || bus0.min_valid !== 1'b0 || bus0.count !== 3'd0 || bus0.pop_record !== 48'h0) begin errors++; $display("FAIL drain_empty: got empty=%b valid=%b count=%0d rec=%h expected 1/0/0/0", bus0.empty, bus0.min_valid, bus0.count, bus0.pop_record); end
   endtask

   task automatic test_overflow();
      cyc0(1'b1, mk(16'd8, 8'd1), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd2, 8'd2), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd6, 8'd3), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd5, 8'd4), 1'b0, 1'b0);
      vectors++; if (bus0.overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", bus0.overflow); end
      cyc0(1'b1, mk(16'd1, 8'd9), 1'b0, 1'b0);
      vectors++; if (bus0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus0.overflow); end
      vectors++; if (bus0.count !== 3'd4 || bus0.pop_record !== mk(16'd2, 8'd2)) begin errors++; $display("FAIL ovf_dropped: got count=%0d rec=%h expected 4/%h", bus0.count, bus0.pop_record, mk(16'd2, 8'd2)); end
      cyc0(1'b0, '0, 1'b0, 1'b0);
      vectors++; if (bus0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus0.overflow); end
   endtask

   task automatic test_push_pop_full();
      logic [47:0] exp_q [4];
      exp_q[0] = mk(16'd1, 8'd5); exp_q[1] = mk(16'd5, 8'd4);
      exp_q[2] = mk(16'd6, 8'd3); exp_q[3] = mk(16'd8, 8'd1);
      vectors++; if (bus0.pop_record !== mk(16'd2, 8'd2)) begin errors++; $display("FAIL pp_popped: got %h expected %h", bus0.pop_record, mk(16'd2, 8'd2)); end
      cyc0(1'b1, mk(16'd1, 8'd5), 1'b1, 1'b0);
      vectors++; if (bus0.count !== 3'd4 || bus0.full !== 1'b1) begin errors++; $display("FAIL pp_count: got count=%0d full=%b expected 4/1", bus0.count, bus0.full); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (bus0.pop_record !== exp_q[i]) begin errors++; $display("FAIL pp_drain%0d: got %h expected %h", i, bus0.pop_record, exp_q[i]); end
         cyc0(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_underflow();
      vectors++; if (bus0.underflow !== 1'b0) begin errors++; $display("FAIL udf_before: got %b expected 0", bus0.underflow); end
      cyc0(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (bus0.underflow !== 1'b1 || bus0.count !== 3'd0 || bus0.empty !== 1'b1) begin errors++; $display("FAIL udf_set: got udf=%b count=%0d empty=%b expected 1/0/1", bus0.underflow, bus0.count, bus0.empty); end
      cyc0(1'b1, mk(16'd5, 8'd1), 1'b0, 1'b0);
      vectors++; if (bus0.min_valid !== 1'b1 || bus0.pop_record !== mk(16'd5, 8'd1) || bus0.underflow !== 1'b1) begin errors++; $display("FAIL udf_push: got valid=%b rec=%h udf=%b expected 1/%h/1", bus0.min_valid, bus0.pop_record, bus0.underflow, mk(16'd5, 8'd1)); end
   endtask

   task automatic test_back_to_back();
      cyc0(1'b1, mk(16'd4, 8'd2), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd1, 8'd3), 1'b0, 1'b0);
      vectors++; if (bus0.pop_record !== mk(16'd1, 8'd3) || bus0.count !== 3'd3) begin errors++; $display("FAIL b2b_fill: got rec=%h count=%0d expected %h/3", bus0.pop_record, bus0.count, mk(16'd1, 8'd3)); end
      cyc0(1'b1, mk(16'd2, 8'd4), 1'b1, 1'b0);
      vectors++; if (bus0.pop_record !== mk(16'd2, 8'd4) || bus0.count !== 3'd3) begin errors++; $display("FAIL b2b_swap: got rec=%h count=%0d expected %h/3", bus0.pop_record, bus0.count, mk(16'd2, 8'd4)); end
      cyc0(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (bus0.pop_record !== mk(16'd4, 8'd2)) begin errors++; $display("FAIL b2b_pop1: got %h expected %h", bus0.pop_record, mk(16'd4, 8'd2)); end
      cyc0(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (bus0.pop_record !== mk(16'd5, 8'd1)) begin errors++; $display("FAIL b2b_pop2: got %h expected %h", bus0.pop_record, mk(16'd5, 8'd1)); end
      cyc0(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (bus0.empty !== 1'b1 || bus0.min_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got empty=%b valid=%b expected 1/0", bus0.empty, bus0.min_valid); end
   endtask

   task automatic test_clear();
      cyc0(1'b1, mk(16'd9, 8'd1), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd8, 8'd2), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd7, 8'd3), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd6, 8'd4), 1'b0, 1'b0);
      cyc0(1'b0, '0, 1'b1, 1'b0);
      cyc0(1'b1, mk(16'd1, 8'd5), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd1, 8'd6), 1'b0, 1'b0);
      vectors++; if (bus0.count !== 3'd4 || bus0.overflow !== 1'b1) begin errors++; $display("FAIL clr_setup: got count=%0d ovf=%b expected 4/1", bus0.count, bus0.overflow); end
      cyc0(1'b0, '0, 1'b1, 1'b0);
      vectors++; if (bus0.count !== 3'd3) begin errors++; $display("FAIL clr_count3: got %0d expected 3", bus0.count); end
      cyc0(1'b1, mk(16'd0, 8'd7), 1'b0, 1'b1);
      vectors++; if (bus0.count !== 3'd0 || bus0.empty !== 1'b1 || bus0.min_valid !== 1'b0) begin errors++; $display("FAIL clr_state: got count=%0d empty=%b valid=%b expected 0/1/0", bus0.count, bus0.empty, bus0.min_valid); end
      vectors++; if (bus0.overflow !== 1'b0 || bus0.underflow !== 1'b0 || bus0.pop_record !== 48'h0) begin errors++; $display("FAIL clr_flags: got ovf=%b udf=%b rec=%h expected 0/0/0", bus0.overflow, bus0.underflow, bus0.pop_record); end
   endtask

   task automatic test_max_mode();
      logic [47:0] exp_q [4];
      exp_q[0] = mk(16'd10, 8'd2); exp_q[1] = mk(16'd10, 8'd3);
      exp_q[2] = mk(16'd4, 8'd1);  exp_q[3] = mk(16'd0, 8'd4);
      cyc1(1'b1, mk(16'd4, 8'd1), 1'b0);
      cyc1(1'b1, mk(16'd10, 8'd2), 1'b0);
      cyc1(1'b1, mk(16'd10, 8'd3), 1'b0);
      cyc1(1'b1, mk(16'd0, 8'd4), 1'b0);
      vectors++; if (bus1.count !== 3'd4 || bus1.full !== 1'b1) begin errors++; $display("FAIL max_full: got count=%0d full=%b expected 4/1", bus1.count, bus1.full); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (bus1.pop_record !== exp_q[i]) begin errors++; $display("FAIL max_pop%0d: got %h expected %h", i, bus1.pop_record, exp_q[i]); end
         cyc1(1'b0, '0, 1'b1);
      end
      vectors++; if (bus1.empty !== 1'b1 || bus1.min_valid !== 1'b0) begin errors++; $display("FAIL max_empty: got empty=%b valid=%b expected 1/0", bus1.empty, bus1.min_valid); end
   endtask

   task automatic test_reset_mid();
      cyc0(1'b0, '0, 1'b1, 1'b0);
      cyc0(1'b1, mk(16'd6, 8'd1), 1'b0, 1'b0);
      cyc0(1'b1, mk(16'd3, 8'd2), 1'b0, 1'b0);
      vectors++; if (bus0.count !== 3'd2 || bus0.underflow !== 1'b1) begin errors++; $display("FAIL rmid_setup: got count=%0d udf=%b expected 2/1", bus0.count, bus0.underflow); end
      rst_b = 1'b1;
      cyc0(1'b1, mk(16'd1, 8'd3), 1'b1, 1'b0);
      rst_b = 1'b0;
      vectors++; if (bus0.count !== 3'd0 || bus0.empty !== 1'b1 || bus0.full !== 1'b0 || bus0.push_wait !== 1'b0) begin errors++; $display("FAIL rmid_count: got count=%0d empty=%b full=%b push_wait=%b expected 0/1/0/0", bus0.count, bus0.empty, bus0.full, bus0.push_wait); end
      vectors++; if (bus0.min_valid !== 1'b0 || bus0.pop_record !== 48'h0 || bus0.underflow !== 1'b0 || bus0.overflow !== 1'b0) begin errors++; $display("FAIL rmid_head: got valid=%b rec=%h udf=%b ovf=%b expected 0/0/0/0", bus0.min_valid, bus0.pop_record, bus0.underflow, bus0.overflow); end
      cyc0(1'b1, mk(16'd5, 8'd4), 1'b0, 1'b0);
      vectors++; if (bus0.pop_record !== mk(16'd5, 8'd4) || bus0.count !== 3'd1) begin errors++; $display("FAIL rmid_recover: got rec=%h count=%0d expected %h/1", bus0.pop_record, bus0.count, mk(16'd5, 8'd4)); end
   endtask

   initial begin
      bus0.push = 1'b0; bus0.push_record = '0; bus0.pop = 1'b0; bus0.clear = 1'b0;
      bus1.push = 1'b0; bus1.push_record = '0; bus1.pop = 1'b0; bus1.clear = 1'b0;
      test_reset();
      test_sorted_drain();
      test_overflow();
      test_push_pop_full();
      test_underflow();
      test_back_to_back();
      test_clear();
      test_max_mode();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/min_queue_param.md
Name: min_queue_param

Overview:
- Parametrised successor to the fixed 48-bit/1024-entry min queue.
- Holds up to DEPTH records in a register-based sorted array, so the best record is always at slot 0 and `pop_record` is a registered output.
- Key width, key position, depth and ordering (min or max) are parameters.
- Push and pop are both accepted in the same cycle, including when the array is full.
- Equal keys leave in arrival order (stable FIFO).
- Sticky overflow/underflow flags support system debug.

Parameters:
- REC_WD, 48: record width in bits.
- KEY_WD, 16: key field width.
- KEY_LSB, 32: bit position of the key LSB inside the record; KEY_LSB+KEY_WD <= REC_WD.
- DEPTH, 16: number of slots, >= 2.
- CNT_WD, 5: width of `count`; must satisfy 2^CNT_WD > DEPTH.
- MAX_MODE, 0: 0 = min queue (smallest key first), 1 = max queue (largest key first).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_b, in, 1: reset, synchronous and active-high.
- clear, in, 1: synchronous flush of all slots; lower priority than rst_b.
- push, in, 1: push request.
- push_record, in, REC_WD: record to insert.
- push_wait, out, 1: registered, equals `full`; while high a push is taken only together with a pop.
- full, out, 1: registered, count == DEPTH.
- pop, in, 1: pop request; accepted only when min_valid = 1.
- pop_record, out, REC_WD: data of slot 0.
- min_valid, out, 1: slot 0 valid.
- empty, out, 1: registered, count == 0.
- count, out, CNT_WD: number of valid records.
- overflow, out, 1: sticky; set by a rejected push.
- underflow, out, 1: sticky; set by a pop while empty.

Behaviour:
- **Reset.** While rst_b = 1, all slots are invalid and slot data is zeroed. Outputs: count = 0, empty = 1, full = 0, push_wait = 0, min_valid = 0, pop_record = 0, overflow = 0, underflow = 0.
- **clear.** Same effect as reset on the slots, count and flags. Any push or pop in the same cycle is ignored.
- **Accept rules.**
  - pop_acc = pop & min_valid.
  - push_acc = push & (!full | pop_acc).
  - push & full & !pop_acc sets overflow; the record is dropped.
  - pop & !min_valid sets underflow.
- **Precedence.** Let k(x) be the key field of record x. Existing slot x precedes the new record n when x is valid and:
  - MAX_MODE = 0: k(x) <= k(n);
  - MAX_MODE = 1: k(x) >= k(n).
  - Comparison is unsigned.
  - Ties put the older record ahead of the newer one.
- **Update, single cycle.** Slots are a[0..DEPTH-1].
  - Base array: b[i] = a[i+1] if pop_acc, else a[i]; b[DEPTH-1] becomes invalid on pop.
  - If push_acc, for each i:
    - next[i] = b[i] if b[i] precedes n;
    - next[i] = n if (i == 0 or b[i-1] precedes n) and b[i] does not precede n;
    - next[i] = b[i-1] otherwise.
  - If no push, next = b.
  - All DEPTH compares are parallel; there is no multi-cycle search.
- **Latency.**
  - A pushed record is visible at pop_record/min_valid one cycle after acceptance if it is the new best.
  - After a pop, the next best is presented the following cycle.
  - Back-to-back pops are sustained every cycle.
- **count.** next = count + push_acc − pop_acc. Flags derive from next count and are registered: full = (next == DEPTH), empty = (next == 0), push_wait = full.
- **Simultaneous push+pop.**
  - count is unchanged.
  - When full, the new record takes a freed slot.
  - A new key better than every remaining key becomes slot 0 on the next cycle.
  - The popped record is the one presented in the cycle of the pop.
- **Invariants.**
  - Valid slots are contiguous from index 0 and ordered per MAX_MODE.
  - Invalid slots hold zeros.
- **Reset mid-operation.** rst_b in any cycle discards all contents regardless of push/pop in that cycle.

Test Plan:
- **Sorted drain.** DEPTH = 4, MAX_MODE = 0; push keys 7, 3, 9, 3(tag B) after 3(tag A) -> full = 1, count = 4; pops return 3A, 3B, 7, 9; empty = 1 after the 4th pop. Checks tie order.
- **Overflow.** Full queue, push key 1 without pop -> record dropped, overflow = 1 and stays set, count = 4, pop_record unchanged.
- **Push+pop when full.** Queue {2, 5, 6, 8}, push key 1 + pop in one cycle -> 2 popped, next pop_record key = 1, count = 4, full stays 1.
- **Max mode.** MAX_MODE = 1; push 4, 10, 10, 0 -> pops return 10 (first), 10 (second), 4, 0.
- **Underflow.** Pop while empty -> underflow = 1, count stays 0. A later push of key 5 -> min_valid = 1 the next cycle with key 5.
- **Mid-operation reset/clear.** Assert clear with count = 3 and simultaneous push -> next cycle count = 0, empty = 1, min_valid = 0, overflow = 0. Assert rst_b mid-burst -> all outputs at reset values the next cycle.
